// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the LC-3 memory initiator.
//   state_t   : initiator FSM states
//   MEM_WORDS : default size of the backing memory, in words
//   KBDR/KBSR/DDR/DSR : memory-mapped I/O register addresses
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int unsigned MEM_WORDS = 1024;

  localparam logic [15:0] KBDR = 16'h03F0;
  localparam logic [15:0] KBSR = 16'h03F1;
  localparam logic [15:0] DDR  = 16'h03F2;
  localparam logic [15:0] DSR  = 16'h03F3;

endpackage

// File: rtl/mem_initiator_if.sv
// Request/response handshake plus memory-bus signals of the initiator.
//   req_valid/req_rw/req_addr/req_wdata : datapath request
//   req_ready                           : request accepted when valid & ready
//   resp_valid/resp_rdata/resp_err      : completion pulse, read data, error
//   mar/mdr/mio_en/rw                   : bus address, write data, enable, direction
//   r/mem_out                           : responder ready and read data
// Modport master is the initiator; slave is the datapath plus responder side.
interface mem_initiator_if;

  logic        req_valid;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        mio_en;
  logic        rw;
  logic        r;
  logic [15:0] mem_out;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, r, mem_out,
    output req_ready, resp_valid, resp_rdata, resp_err, mar, mdr, mio_en, rw
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, r, mem_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, mar, mdr, mio_en, rw
  );

endinterface

// File: rtl/mem_initiator.sv
// Memory initiator: accepts one datapath request at a time, runs it on the
// memory bus (mar/mdr/rw/mio_en, completed by r) and returns a one-cycle
// response. Out-of-range addresses are rejected without touching the bus;
// a responder that stays silent for TIMEOUT access cycles yields an error.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mem_initiator_if.master (request, response and bus signals)
module mem_initiator
  import lc3_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned MEM_WORDS = lc3_mem_pkg::MEM_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  mem_initiator_if.master  bus
);

  localparam logic [16:0] ADDR_LIMIT = 17'(MEM_WORDS);
  localparam logic [3:0]  CNT_LAST   = 4'(TIMEOUT - 1);
  localparam logic [3:0]  CNT_MAX    = 4'(TIMEOUT);

  state_t     state;
  logic [3:0] cnt;
  logic       out_of_range;

  // A lingering r from the previous access must drain before a new accept.
  assign bus.req_ready = (state == IDLE) && !bus.r;
  assign out_of_range  = {1'b0, bus.req_addr} >= ADDR_LIMIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.mar        <= '0;
      bus.mdr        <= '0;
      bus.rw         <= 1'b0;
      bus.mio_en     <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.mar <= bus.req_addr;
            bus.mdr <= bus.req_wdata;
            bus.rw  <= bus.req_rw;
            cnt     <= '0;
            if (out_of_range) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              state          <= RESP;
            end else begin
              bus.mio_en <= 1'b1;
              state      <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // r is checked first so it wins over a simultaneous timeout.
          if (bus.r) begin
            if (!bus.rw) bus.resp_rdata <= bus.mem_out;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.mio_en     <= 1'b0;
            state          <= RESP;
          end else if (cnt == CNT_LAST) begin
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
            bus.resp_valid <= 1'b1;
            bus.mio_en     <= 1'b0;
            cnt            <= CNT_MAX;
            state          <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
